out_reg_cell: RTL and testbench

- Fabric-to-pad output register cell for the ap3 IO tile; the transmit-side counterpart of the input register cell.
- Registers (or bypasses) fabric data toward the pad.
- Sequences the pad output-enable through a drive / bus-turnaround / high-Z state machine, so the pad never re-drives within a guard window after release.
- Whitebox simulation model and synthesis target for the IO placement flow.

---
 rtl/out_reg_cell_pkg.sv | 25 ++
 rtl/out_reg_cell_if.sv | 24 ++
 rtl/out_reg_cell_oe_turn_seq.sv | 82 ++++++++
 rtl/out_reg_cell.sv | 48 ++++
 tb/tb_out_reg_cell.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/out_reg_cell_pkg.sv
// Shared definitions for the ap3 IO-tile output register cell:
// sequencer state encoding, turnaround limits and counter sizing.
package out_reg_pkg;

  typedef logic [1:0] seq_state_t;

  localparam seq_state_t ST_HIZ   = 2'd0;
  localparam seq_state_t ST_DRIVE = 2'd1;
  localparam seq_state_t ST_TURN  = 2'd2;

  localparam int TURN_CYCLES_MAX = 15;

  // Turnaround counter width; a zero-length guard still gets one bit.
  function automatic int cnt_width(input int turn_cycles);
    int w;
    w = $clog2(turn_cycles + 1);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/out_reg_cell_if.sv
// Fabric-side bundle of the output register cell: data, selects,
// output-enable request and the pad-facing results.
interface out_reg_cell_if #(
  parameter int WIDTH = 1
);
  logic             OQCE_inp;
  logic [WIDTH-1:0] F2A_inp;
  logic             OSEL_inp;
  logic             OE_inp;
  logic             OESEL_inp;
  logic [WIDTH-1:0] OQZ_out;
  logic             OEZ_out;
  logic             BUSY_out;

  modport master (
    output OQCE_inp, F2A_inp, OSEL_inp, OE_inp, OESEL_inp,
    input  OQZ_out, OEZ_out, BUSY_out
  );

  modport slave (
    input  OQCE_inp, F2A_inp, OSEL_inp, OE_inp, OESEL_inp,
    output OQZ_out, OEZ_out, BUSY_out
  );
endinterface

// File: rtl/out_reg_cell_oe_turn_seq.sv
// Pad output-enable sequencer: HIZ -> DRIVE -> TURN -> HIZ, holding the pad
// released for TURN_CYCLES guard cycles after the enable request drops.
module oe_turn_seq
  import out_reg_pkg::*;
#(
  parameter int TURN_CYCLES = 1
) (
  input  logic OQC,
  input  logic QRT,
  input  logic OE,
  output logic oe_q,
  output logic busy
);

  localparam int TC = (TURN_CYCLES > TURN_CYCLES_MAX) ? TURN_CYCLES_MAX : TURN_CYCLES;
  localparam int CW = cnt_width(TC);
  localparam logic [CW-1:0] TURN_LOAD = CW'(TC - 1);
  // With no guard window the drive exit lands straight back in HIZ.
  localparam seq_state_t RELEASE_ST = (TC == 0) ? ST_HIZ : ST_TURN;

  seq_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          oe_d, busy_d, busy_q;

  // State, counter and registered output flags
  always_ff @(posedge OQC) begin
    if (QRT) begin
      state_q <= ST_HIZ;
      cnt_q   <= {CW{1'b0}};
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and counter; ternaries keep an X on OE visible in the state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_HIZ: begin
        state_d = OE ? ST_DRIVE : ST_HIZ;
      end
      ST_DRIVE: begin
        state_d = OE ? ST_DRIVE : RELEASE_ST;
        cnt_d   = (OE || (TC == 0)) ? cnt_q : TURN_LOAD;
      end
      ST_TURN: begin
        if (cnt_q == {CW{1'b0}}) begin
          state_d = ST_HIZ;
        end else begin
          cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_HIZ;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // Output decode of the upcoming state, captured with the state register
  always_comb begin
    oe_d   = 1'b0;
    busy_d = 1'b0;
    case (state_d)
      ST_DRIVE: oe_d   = 1'b1;
      ST_TURN:  busy_d = 1'b1;
      default: begin
        oe_d   = 1'b0;
        busy_d = 1'b0;
      end
    endcase
  end

  assign busy = busy_q;

endmodule

// File: rtl/out_reg_cell.sv
// Fabric-to-pad output register cell: data register with bypass select and
// output-enable path with sequenced or direct selection.
module out_reg_cell #(
  parameter int WIDTH       = 1,
  parameter int TURN_CYCLES = 1
) (
  input  logic          OQC,
  input  logic          QRT,
  out_reg_cell_if.slave io
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             seq_oe, seq_busy;

  // Data register next value; loads on clock enable, independent of the sequencer
  always_comb begin
    data_d = data_q;
    if (io.OQCE_inp) begin
      data_d = io.F2A_inp;
    end else begin
      data_d = data_q;
    end
  end

  // Data register
  always_ff @(posedge OQC) begin
    if (QRT) begin
      data_q <= {WIDTH{1'b0}};
    end else begin
      data_q <= data_d;
    end
  end

  oe_turn_seq #(
    .TURN_CYCLES (TURN_CYCLES)
  ) u_seq (
    .OQC  (OQC),
    .QRT  (QRT),
    .OE   (io.OE_inp),
    .oe_q (seq_oe),
    .busy (seq_busy)
  );

  assign io.OQZ_out  = io.OSEL_inp  ? io.F2A_inp : data_q;
  assign io.OEZ_out  = io.OESEL_inp ? io.OE_inp  : seq_oe;
  assign io.BUSY_out = seq_busy;

endmodule

// File: tb/tb_out_reg_cell.sv
// Scoreboard bench for out_reg_cell: three instances (guard 3, 0, 5) share one
// stimulus stream; a guard-countdown reference model predicts every output.
module tb_out_reg_cell;

  typedef struct {
    int         id;
    logic [3:0] oqz;
    logic       oez;
    logic       busy;
  } exp_t;

  logic       clk = 1'b0;
  logic       qrt;
  logic       oqce, osel, oe, oesel;
  logic [3:0] f2a;

  always #5 clk = ~clk;

  out_reg_cell_if #(.WIDTH(4)) if_a ();
  out_reg_cell_if #(.WIDTH(1)) if_b ();
  out_reg_cell_if #(.WIDTH(4)) if_c ();

  assign if_a.OQCE_inp = oqce;  assign if_b.OQCE_inp = oqce;  assign if_c.OQCE_inp = oqce;
  assign if_a.F2A_inp  = f2a;   assign if_b.F2A_inp  = f2a[0]; assign if_c.F2A_inp = f2a;
  assign if_a.OSEL_inp = osel;  assign if_b.OSEL_inp = osel;  assign if_c.OSEL_inp = osel;
  assign if_a.OE_inp   = oe;    assign if_b.OE_inp   = oe;    assign if_c.OE_inp   = oe;
  assign if_a.OESEL_inp = oesel; assign if_b.OESEL_inp = oesel; assign if_c.OESEL_inp = oesel;

  out_reg_cell #(.WIDTH(4), .TURN_CYCLES(3)) dut_a (.OQC(clk), .QRT(qrt), .io(if_a.slave));
  out_reg_cell #(.WIDTH(1), .TURN_CYCLES(0)) dut_b (.OQC(clk), .QRT(qrt), .io(if_b.slave));
  out_reg_cell #(.WIDTH(4), .TURN_CYCLES(5)) dut_c (.OQC(clk), .QRT(qrt), .io(if_c.slave));

  int         checks = 0;
  int         errors = 0;
  exp_t       sb[$];
  event       chk_ev;
  bit         win_on = 1'b0;
  int         busy_cnt[3];
  int         low_cnt[3];

  // Reference model: drive flag, remaining guard cycles, data register image.
  int         tc[3]    = '{3, 0, 5};
  logic [3:0] wmask[3] = '{4'hF, 4'h1, 4'hF};
  bit         drive_m[3];
  int         guard_m[3];
  logic [3:0] data_m[3];

  task automatic check(input string name, input int id, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual %h expected %h at %0t", name, id, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      drive_m[i] = 1'b0;
      guard_m[i] = 0;
      data_m[i]  = 4'h0;
    end
  endtask

  task automatic model_step(input bit r, input bit ce, input logic [3:0] d, input bit e);
    if (r) begin
      model_reset();
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (ce) data_m[i] = d & wmask[i];
        if (guard_m[i] > 0) begin
          guard_m[i] = guard_m[i] - 1;
        end else if (drive_m[i]) begin
          if (!e) begin
            drive_m[i] = 1'b0;
            guard_m[i] = tc[i];
          end
        end else if (e) begin
          drive_m[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic cycle(input bit r, input bit ce, input logic [3:0] d,
                       input bit os, input bit e, input bit es);
    exp_t x;
    @(negedge clk);
    qrt = r; oqce = ce; f2a = d; osel = os; oe = e; oesel = es;
    #1;
    for (int i = 0; i < 3; i++) begin
      x.id   = i;
      x.oqz  = os ? (d & wmask[i]) : data_m[i];
      x.oez  = es ? e : drive_m[i];
      x.busy = (guard_m[i] > 0);
      sb.push_back(x);
    end
    ->chk_ev;
    @(posedge clk);
    model_step(r, ce, d, e);
  endtask

  // Monitor: pops every queued expectation and compares against the instance
  initial begin
    exp_t       e;
    logic [3:0] a_oqz;
    logic       a_oez, a_busy;
    forever begin
      @(chk_ev);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.id)
          0: begin a_oqz = if_a.OQZ_out; a_oez = if_a.OEZ_out; a_busy = if_a.BUSY_out; end
          1: begin a_oqz = {3'b000, if_b.OQZ_out}; a_oez = if_b.OEZ_out; a_busy = if_b.BUSY_out; end
          default: begin a_oqz = if_c.OQZ_out; a_oez = if_c.OEZ_out; a_busy = if_c.BUSY_out; end
        endcase
        check("oqz",  e.id, a_oqz, e.oqz);
        check("oez",  e.id, {3'b000, a_oez},  {3'b000, e.oez});
        check("busy", e.id, {3'b000, a_busy}, {3'b000, e.busy});
        if (win_on) begin
          if (a_busy === 1'b1) busy_cnt[e.id]++;
          if (a_oez === 1'b0)  low_cnt[e.id]++;
        end
      end
    end
  end

  initial begin
    bit       r_oe;
    qrt = 1'b1; oqce = 1'b1; f2a = 4'h1; osel = 1'b0; oe = 1'b1; oesel = 1'b0;
    @(posedge clk);
    model_reset();

    // Reset held with OE high, then first edge after release drives
    cycle(1'b1, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0);

    // Data path: registered, hold, bypass
    cycle(1'b0, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 4'h3, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

    // Turnaround: OE high 4, low 1, then high; count released cycles
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin busy_cnt[i] = 0; low_cnt[i] = 0; end
    win_on = 1'b1;
    cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    win_on = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("turn_busy_len", i, busy_cnt[i][3:0], tc[i][3:0]);
      check("turn_low_len",  i, low_cnt[i][3:0],  4'(tc[i] + 1));
    end

    // Reset on the second TURN cycle with OE held high
    cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

    // Bypass: OE toggling, then drop bypass in the middle of TURN
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 4'h0, 1'b0, i[0], 1'b1);
    cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

    // Randomised traffic with occasional resets and sticky OE
    r_oe = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r_oe = ~r_oe;
      cycle(($urandom_range(0, 40) == 0), 1'($urandom), 4'($urandom),
            ($urandom_range(0, 3) == 0), r_oe, ($urandom_range(0, 4) == 0));
    end

    @(negedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain actual %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
